// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and a small address helper used by the
// instruction-memory responder and its response FIFO.
package cpu_pkg;

  localparam int                  INSTR_W   = 32;
  localparam int                  ADDR_W    = 64;
  localparam logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]   PC_RESET  = 64'd40;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Show-ahead response FIFO; a synchronous clear empties it but keeps a same-cycle
// push so a redirect target accepted together with a flush is not lost.
module imem_rsp_fifo #(
  parameter  int WIDTH = 97,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  import cpu_pkg::*;

  logic [WIDTH-1:0] buf_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake qualification and head presentation.
  always_comb begin
    do_push_s = push & ~clr & (cnt_r < CNT_W'(DEPTH));
    do_pop_s  = pop & ~clr & (cnt_r != {CNT_W{1'b0}});
    valid     = (cnt_r != {CNT_W{1'b0}});
    count     = cnt_r;
    if (valid) begin
      pop_data = buf_r[rd_ptr_r];
    end else begin
      pop_data = {WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (clr) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= push ? ptr_inc({PTR_W{1'b0}}) : {PTR_W{1'b0}};
      cnt_r    <= push ? CNT_W'(1) : {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      cnt_r <= cnt_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (clr && push) begin
      buf_r[0] <= push_data;
    end else if (do_push_s) begin
      buf_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline with credit-based
// flow control into a show-ahead response FIFO, branch flush and a load port.
module imem_fetch_responder #(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int DATA_W    = cpu_pkg::INSTR_W,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  import cpu_pkg::*;

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int FIFO_W = ADDR_W + DATA_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              accept_s;
  logic              req_err_s;
  logic              ld_ok_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [CNT_W-1:0]  inflight_s;
  logic [CNT_W:0]    credit_s;
  logic              push_s;
  logic [FIFO_W-1:0] push_data_s;
  logic [FIFO_W-1:0] pop_data_s;
  logic              fifo_valid_s;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return ((a >> 2) >= ADDR_W'(DEPTH));
  endfunction

  // Credit check, request classification and the combinational array read.
  always_comb begin
    credit_s  = {1'b0, fifo_cnt_s} + {1'b0, inflight_s};
    req_err_s = misaligned(req_addr[1:0]) | out_of_range(req_addr);
    ld_ok_s   = ld_en & ~out_of_range(ld_addr);
    // A flush empties everything at this edge, so the redirect target always fits.
    if (flush) begin
      req_ready = 1'b1;
    end else begin
      req_ready = (credit_s < (CNT_W + 1)'(RSP_DEPTH));
    end
    accept_s = req_valid & req_ready;
    if (req_err_s) begin
      rd_word_s = DATA_W'(NOP_INSTR);
    end else begin
      rd_word_s = mem_r[req_addr[2 +: IDX_W]];
    end
  end

  // Program-image load; the read above sees the old word in the same cycle.
  always_ff @(posedge clk) begin
    if (ld_ok_s) begin
      mem_r[ld_addr[2 +: IDX_W]] <= ld_data;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_s      = accept_s;
      assign push_data_s = {req_addr, rd_word_s, req_err_s};
      assign inflight_s  = {CNT_W{1'b0}};
    end else begin : g_pipe
      localparam int PIPE = LATENCY - 1;
      logic [PIPE-1:0]   vld_r;
      logic [FIFO_W-1:0] ent_r [PIPE];
      logic [CNT_W-1:0]  cnt_r;

      // Request stages and in-flight credit count; flush drops all but this cycle's accept.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_r <= {PIPE{1'b0}};
          cnt_r <= {CNT_W{1'b0}};
          for (int i = 0; i < PIPE; i++) ent_r[i] <= {FIFO_W{1'b0}};
        end else begin
          vld_r[0] <= accept_s;
          ent_r[0] <= {req_addr, rd_word_s, req_err_s};
          for (int i = 1; i < PIPE; i++) begin
            vld_r[i] <= vld_r[i-1] & ~flush;
            ent_r[i] <= ent_r[i-1];
          end
          if (flush) begin
            cnt_r <= CNT_W'(accept_s);
          end else begin
            cnt_r <= cnt_r + CNT_W'(accept_s) - CNT_W'(vld_r[PIPE-1]);
          end
        end
      end

      assign push_s      = vld_r[PIPE-1] & ~flush;
      assign push_data_s = ent_r[PIPE-1];
      assign inflight_s  = cnt_r;
    end
  endgenerate

  imem_rsp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (rsp_ready),
    .pop_data  (pop_data_s),
    .valid     (fifo_valid_s),
    .count     (fifo_cnt_s)
  );

  assign rsp_valid = fifo_valid_s;
  assign {rsp_addr, rsp_instr, rsp_err} = pop_data_s;

endmodule
